// File: rtl/ft600_fifo_responder.sv
// Device-side FT600 245-mode FIFO bus responder with host valid/ready streams.
// Optional read/write word counters are enabled by defining FT600_RESP_STATS_EN.
module ft600_fifo_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                  CLK,
  input  logic                  nRST,
  output logic                  usb_rxf,
  output logic                  usb_txe,
  input  logic                  usb_rd_n,
  input  logic                  usb_wr_n,
  input  logic                  usb_oe_n,
  input  logic [DATA_WIDTH-1:0] usb_ad_i,
  output logic [DATA_WIDTH-1:0] usb_ad_o,
  output logic                  usb_ad_oe,
  input  logic [DATA_WIDTH-1:0] host_rx_data,
  input  logic                  host_rx_valid,
  output logic                  host_rx_ready,
  output logic [DATA_WIDTH-1:0] host_tx_data,
  output logic                  host_tx_valid,
  input  logic                  host_tx_ready,
  output logic                  err_underflow,
  output logic                  err_overflow,
  output logic                  err_conflict
`ifdef FT600_RESP_STATS_EN
  ,
  output logic [31:0]           stat_rd_words,
  output logic [31:0]           stat_wr_words
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] rx_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] tx_mem_q [DEPTH];

  logic [PW-1:0] rx_wr_q, rx_rd_q, tx_wr_q, tx_rd_q;
  logic [CW-1:0] rx_count_q, rx_count_d, tx_count_q, tx_count_d;

  logic rxf_q, txe_q, rx_ready_q, tx_valid_q, ad_oe_q;
  logic err_underflow_q, err_overflow_q, err_conflict_q;

  logic rd_req, rx_push, rx_pop, tx_push, tx_pop;

  assign rd_req  = !usb_rd_n && !usb_oe_n;
  assign rx_push = host_rx_valid && rx_ready_q;
  assign rx_pop  = rd_req && (rx_count_q != '0);
  assign tx_push = !usb_wr_n && (tx_count_q != FULL);
  assign tx_pop  = tx_valid_q && host_tx_ready;

  always_comb begin
    rx_count_d = rx_count_q;
    if (rx_push && !rx_pop)
      rx_count_d = rx_count_q + CW'(1);
    else if (!rx_push && rx_pop)
      rx_count_d = rx_count_q - CW'(1);

    tx_count_d = tx_count_q;
    if (tx_push && !tx_pop)
      tx_count_d = tx_count_q + CW'(1);
    else if (!tx_push && tx_pop)
      tx_count_d = tx_count_q - CW'(1);
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge CLK) begin
    if (rx_push) rx_mem_q[rx_wr_q] <= host_rx_data;
    if (tx_push) tx_mem_q[tx_wr_q] <= usb_ad_i;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rx_wr_q         <= '0;
      rx_rd_q         <= '0;
      tx_wr_q         <= '0;
      tx_rd_q         <= '0;
      rx_count_q      <= '0;
      tx_count_q      <= '0;
      rxf_q           <= 1'b1;
      txe_q           <= 1'b1;
      rx_ready_q      <= 1'b0;
      tx_valid_q      <= 1'b0;
      ad_oe_q         <= 1'b0;
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
      err_conflict_q  <= 1'b0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + PW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + PW'(1);
      if (tx_push) tx_wr_q <= tx_wr_q + PW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + PW'(1);
      rx_count_q      <= rx_count_d;
      tx_count_q      <= tx_count_d;
      rxf_q           <= (rx_count_d == '0);
      txe_q           <= (tx_count_d == FULL);
      rx_ready_q      <= (rx_count_d != FULL);
      tx_valid_q      <= (tx_count_d != '0);
      ad_oe_q         <= !usb_oe_n;
      err_underflow_q <= err_underflow_q | (rd_req && (rx_count_q == '0));
      err_overflow_q  <= err_overflow_q | (!usb_wr_n && (tx_count_q == FULL));
      err_conflict_q  <= err_conflict_q | (!usb_wr_n && ad_oe_q);
    end
  end

`ifdef FT600_RESP_STATS_EN
  logic [31:0] stat_rd_q, stat_wr_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
    end else begin
      if (rx_pop)  stat_rd_q <= stat_rd_q + 32'd1;
      if (tx_push) stat_wr_q <= stat_wr_q + 32'd1;
    end
  end

  assign stat_rd_words = stat_rd_q;
  assign stat_wr_words = stat_wr_q;
`endif

  assign usb_rxf       = rxf_q;
  assign usb_txe       = txe_q;
  assign usb_ad_oe     = ad_oe_q;
  assign usb_ad_o      = (rx_count_q == '0) ? '0 : rx_mem_q[rx_rd_q];
  assign host_rx_ready = rx_ready_q;
  assign host_tx_valid = tx_valid_q;
  assign host_tx_data  = tx_mem_q[tx_rd_q];
  assign err_underflow = err_underflow_q;
  assign err_overflow  = err_overflow_q;
  assign err_conflict  = err_conflict_q;

endmodule

// File: tb/tb_ft600_fifo_responder.sv
// Scoreboard bench for ft600_fifo_responder: stimulus enqueues expected words,
// a negedge monitor compares whatever the DUT hands out on the bus or host stream.
module tb_ft600_fifo_responder;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        usb_rxf, usb_txe, usb_ad_oe;
  logic        usb_rd_n, usb_wr_n, usb_oe_n;
  logic [15:0] usb_ad_i, usb_ad_o;
  logic [15:0] host_rx_data, host_tx_data;
  logic        host_rx_valid, host_rx_ready;
  logic        host_tx_valid, host_tx_ready;
  logic        err_underflow, err_overflow, err_conflict;
`ifdef FT600_RESP_STATS_EN
  logic [31:0] stat_rd_words, stat_wr_words;
`endif

  ft600_fifo_responder #(.DATA_WIDTH(16), .DEPTH(16)) dut (
    .CLK(CLK), .nRST(nRST),
    .usb_rxf(usb_rxf), .usb_txe(usb_txe),
    .usb_rd_n(usb_rd_n), .usb_wr_n(usb_wr_n), .usb_oe_n(usb_oe_n),
    .usb_ad_i(usb_ad_i), .usb_ad_o(usb_ad_o), .usb_ad_oe(usb_ad_oe),
    .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
    .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
    .err_underflow(err_underflow), .err_overflow(err_overflow), .err_conflict(err_conflict)
`ifdef FT600_RESP_STATS_EN
    , .stat_rd_words(stat_rd_words), .stat_wr_words(stat_wr_words)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_rd [$];
  logic [15:0] exp_tx [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: a master read with data present, or a host-side TX handshake.
  always @(negedge CLK) begin
    if (nRST) begin
      if (!usb_rd_n && !usb_oe_n && !usb_rxf) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected actual=%h required=none", usb_ad_o);
        end else chk("rd_data", {16'h0, usb_ad_o}, {16'h0, exp_rd.pop_front()});
      end
      if (host_tx_valid && host_tx_ready) begin
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected actual=%h required=none", host_tx_data);
        end else chk("tx_data", {16'h0, host_tx_data}, {16'h0, exp_tx.pop_front()});
      end
    end
  end

  task automatic host_push(input logic [15:0] d);
    host_rx_valid = 1'b1;
    host_rx_data  = d;
    exp_rd.push_back(d);
    tick();
    host_rx_valid = 1'b0;
  endtask

  initial begin
    int idx;
    nRST = 1'b0;
    usb_rd_n = 1'b1; usb_wr_n = 1'b1; usb_oe_n = 1'b1;
    usb_ad_i = '0; host_rx_data = '0; host_rx_valid = 1'b0; host_tx_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_rxf", usb_rxf, 1);
    chk("rst_txe", usb_txe, 1);
    chk("rst_ad_oe", usb_ad_oe, 0);
    chk("rst_rx_ready", host_rx_ready, 0);
    chk("rst_tx_valid", host_tx_valid, 0);
    chk("rst_errs", {err_underflow, err_overflow, err_conflict}, 0);

    nRST = 1'b1;
    repeat (3) tick();
    chk("idle_rxf", usb_rxf, 1);
    chk("idle_txe", usb_txe, 0);
    chk("idle_rx_ready", host_rx_ready, 1);
    chk("idle_ad_oe", usb_ad_oe, 0);
    chk("idle_errs", {err_underflow, err_overflow, err_conflict}, 0);

    // Three host words read back by the master
    host_push(16'h1111);
    host_push(16'h2222);
    host_push(16'h3333);
    chk("rx3_rxf", usb_rxf, 0);
    usb_oe_n = 1'b0;
    tick();
    chk("turn_ad_oe", usb_ad_oe, 1);
    usb_rd_n = 1'b0;
    tick();
    tick();
    chk("rd2_rxf", usb_rxf, 0);
    tick();
    chk("rd3_rxf", usb_rxf, 1);
    usb_rd_n = 1'b1;
    chk("rd3_underflow", err_underflow, 0);

    // Underflow: read while empty, then normal traffic still works
    usb_rd_n = 1'b0;
    tick();
    usb_rd_n = 1'b1;
    chk("uf_err", err_underflow, 1);
    chk("uf_rxf", usb_rxf, 1);
    host_push(16'h4444);
    usb_rd_n = 1'b0;
    tick();
    usb_rd_n = 1'b1;
    chk("uf_after_rxf", usb_rxf, 1);
    usb_oe_n = 1'b1;
    tick();
    chk("turn_back_ad_oe", usb_ad_oe, 0);

    // TX overflow: 16 accepted writes, 17th dropped
    for (int i = 0; i < 16; i++) begin
      usb_wr_n = 1'b0;
      usb_ad_i = 16'(i);
      exp_tx.push_back(16'(i));
      tick();
      if (i == 14) chk("tx15_txe", usb_txe, 0);
    end
    chk("tx16_txe", usb_txe, 1);
    usb_ad_i = 16'hDEAD;
    tick();
    usb_wr_n = 1'b1;
    chk("ov_err", err_overflow, 1);
    chk("ov_no_conflict", err_conflict, 0);
    host_tx_ready = 1'b1;
    repeat (20) tick();
    chk("tx_drain_valid", host_tx_valid, 0);
    chk("tx_drain_txe", usb_txe, 0);
    chk("tx_queue_left", exp_tx.size(), 0);

    // Conflict: write while responder owns the bus; word still accepted
    usb_oe_n = 1'b0;
    tick();
    usb_wr_n = 1'b0;
    usb_ad_i = 16'h5A5A;
    exp_tx.push_back(16'h5A5A);
    tick();
    usb_wr_n = 1'b1;
    usb_oe_n = 1'b1;
    chk("cf_err", err_conflict, 1);
    repeat (3) tick();
    chk("cf_tx_queue_left", exp_tx.size(), 0);

    // RX fill, pop with simultaneous rejected push, then wrap traffic
    for (int i = 0; i < 16; i++) host_push(16'h0100 + 16'(i));
    chk("full_rx_ready", host_rx_ready, 0);
    usb_oe_n = 1'b0;
    tick();
    host_rx_valid = 1'b1;
    host_rx_data  = 16'hBEEF;
    usb_rd_n      = 1'b0;
    tick();
    usb_rd_n      = 1'b1;
    host_rx_valid = 1'b0;
    chk("pop15_rx_ready", host_rx_ready, 1);
    host_push(16'hBEEF);
    chk("refull_rx_ready", host_rx_ready, 0);

    idx = 0;
    usb_rd_n = 1'b0;
    for (int c = 0; c < 80 && !(idx == 16 && usb_rxf && exp_rd.size() == 0); c++) begin
      if (idx < 16 && host_rx_ready) begin
        host_rx_valid = 1'b1;
        host_rx_data  = 16'h0200 + 16'(idx);
        exp_rd.push_back(16'h0200 + 16'(idx));
        idx++;
      end else host_rx_valid = 1'b0;
      tick();
    end
    usb_rd_n = 1'b1;
    host_rx_valid = 1'b0;
    chk("wrap_pushed", idx, 16);
    chk("wrap_rxf", usb_rxf, 1);
    chk("wrap_rd_queue_left", exp_rd.size(), 0);
    chk("final_underflow", err_underflow, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
